// File: rtl/ldst_unit_pkg.sv
// Shared definitions for the load/store unit: RV funct3 codes and FSM states.
// Imported by ldst_align and ldst_unit.
// No ports.
package ldst_unit_pkg;

  // Load encodings of funct3
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  // Store encodings of funct3
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BREQ,
    ST_BRSP,
    ST_RSP
  } state_t;

endpackage

// File: rtl/ldst_unit_if.sv
// Bundle of the execution-unit load/store channel and the data-bus channel.
// Ports: ldst_req_* / ldst_rsp_* toward the execution unit, dbus_req_* / dbus_rsp_* toward memory.
// Modport slave is the load/store unit's view; master is the surrounding environment's view.
interface ldst_unit_if #(parameter int XLEN = 32);

  logic            ldst_req_vld;
  logic            ldst_req_rdy;
  logic            ldst_req_st;
  logic [2:0]      ldst_req_funct3;
  logic [XLEN-1:0] ldst_req_addr;
  logic [XLEN-1:0] ldst_req_wdata;

  logic            ldst_rsp_vld;
  logic            ldst_rsp_rdy;
  logic [XLEN-1:0] ldst_rsp_rdata;
  logic            ldst_rsp_err;

  logic            dbus_req_vld;
  logic            dbus_req_rdy;
  logic            dbus_req_we;
  logic [XLEN-1:0] dbus_req_addr;
  logic [XLEN-1:0] dbus_req_wdata;
  logic [3:0]      dbus_req_wstrb;

  logic            dbus_rsp_vld;
  logic            dbus_rsp_rdy;
  logic [XLEN-1:0] dbus_rsp_rdata;

  modport slave (
    input  ldst_req_vld, ldst_req_st, ldst_req_funct3, ldst_req_addr, ldst_req_wdata,
    output ldst_req_rdy,
    output ldst_rsp_vld, ldst_rsp_rdata, ldst_rsp_err,
    input  ldst_rsp_rdy,
    output dbus_req_vld, dbus_req_we, dbus_req_addr, dbus_req_wdata, dbus_req_wstrb,
    input  dbus_req_rdy,
    input  dbus_rsp_vld, dbus_rsp_rdata,
    output dbus_rsp_rdy
  );

  modport master (
    output ldst_req_vld, ldst_req_st, ldst_req_funct3, ldst_req_addr, ldst_req_wdata,
    input  ldst_req_rdy,
    input  ldst_rsp_vld, ldst_rsp_rdata, ldst_rsp_err,
    output ldst_rsp_rdy,
    input  dbus_req_vld, dbus_req_we, dbus_req_addr, dbus_req_wdata, dbus_req_wstrb,
    output dbus_req_rdy,
    output dbus_rsp_vld, dbus_rsp_rdata,
    input  dbus_rsp_rdy
  );

endinterface

// File: rtl/ldst_unit_align.sv
// Purpose: combinational alignment logic - error check, store lane generation, load extract/extend.
// Latency: purely combinational (0 cycles).
// Backpressure: none; the caller decides when the results are sampled.
// Ports: i_st/i_funct3/i_off describe the access, i_wdata is right-aligned store data,
//        i_rword is the bus read word; o_err, o_wstrb, o_wdata, o_rdata are the decoded results.
module ldst_align import ldst_unit_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            i_st,
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_off,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [XLEN-1:0] i_rword,
  output logic            o_err,
  output logic [3:0]      o_wstrb,
  output logic [XLEN-1:0] o_wdata,
  output logic [XLEN-1:0] o_rdata
);

  logic            w_illegal;
  logic            w_misalign;
  logic [XLEN-1:0] w_shifted;

  // Unsigned variants exist only for loads; 3, 6 and 7 are never legal.
  always_comb begin
    w_illegal = 1'b1;
    case (i_funct3)
      F3_LB, F3_LH, F3_LW: w_illegal = 1'b0;
      F3_LBU, F3_LHU:      w_illegal = i_st;
      default:             w_illegal = 1'b1;
    endcase
  end

  // funct3[1:0] is the access size for every legal code.
  assign w_misalign = ((i_funct3[1:0] == 2'b01) && i_off[0]) ||
                      ((i_funct3[1:0] == 2'b10) && (i_off != 2'b00));
  assign o_err = w_illegal | w_misalign;

  // Sub-word stores replicate the data across the word so that the strobe alone selects the lane.
  always_comb begin
    o_wstrb = 4'b0000;
    o_wdata = '0;
    if (i_st) begin
      case (i_funct3)
        F3_SB: begin
          o_wstrb = 4'b0001 << i_off;
          o_wdata = {(XLEN/8){i_wdata[7:0]}};
        end
        F3_SH: begin
          o_wstrb = 4'b0011 << i_off;
          o_wdata = {(XLEN/16){i_wdata[15:0]}};
        end
        F3_SW: begin
          o_wstrb = 4'b1111;
          o_wdata = i_wdata;
        end
        default: ;
      endcase
    end
  end

  assign w_shifted = i_rword >> {i_off, 3'b000};

  always_comb begin
    o_rdata = '0;
    case (i_funct3)
      F3_LB:   o_rdata = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
      F3_LH:   o_rdata = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
      F3_LW:   o_rdata = w_shifted;
      F3_LBU:  o_rdata = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
      F3_LHU:  o_rdata = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
      default: o_rdata = '0;
    endcase
    if (i_st) o_rdata = '0;
  end

endmodule

// File: rtl/ldst_unit.sv
// Purpose: load/store responder - one request at a time, aligned bus access, one response each.
// Latency: accept in cycle 0, bus request cycle 1, response cycle 3 minimum; errors respond in cycle 1.
// Backpressure: holds bus and response payloads stable until ready; takes new requests only in IDLE.
// Ports: clk, rst (sync, active-high); io_bus carries ldst_req/ldst_rsp (slave side) and dbus_req/dbus_rsp.
module ldst_unit import ldst_unit_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  ldst_unit_if.slave  io_bus
);

  state_t          r_state;
  state_t          w_state_nxt;

  logic            r_st;
  logic [2:0]      r_funct3;
  logic [1:0]      r_off;
  logic            r_we;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [3:0]      r_wstrb;
  logic [XLEN-1:0] r_rdata;
  logic            r_err;

  logic            w_accept;
  logic            w_bus_done;
  logic            w_st;
  logic [2:0]      w_funct3;
  logic [1:0]      w_off;
  logic            w_err;
  logic [3:0]      w_wstrb;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_rdata;

  assign w_accept   = (r_state == ST_IDLE) && io_bus.ldst_req_vld;
  assign w_bus_done = (r_state == ST_BRSP) && io_bus.dbus_rsp_vld;

  // One aligner serves both phases: request decode in IDLE, load extract from the held request later.
  assign w_st     = (r_state == ST_IDLE) ? io_bus.ldst_req_st        : r_st;
  assign w_funct3 = (r_state == ST_IDLE) ? io_bus.ldst_req_funct3    : r_funct3;
  assign w_off    = (r_state == ST_IDLE) ? io_bus.ldst_req_addr[1:0] : r_off;

  ldst_align #(.XLEN(XLEN)) u_align (
    .i_st     (w_st),
    .i_funct3 (w_funct3),
    .i_off    (w_off),
    .i_wdata  (io_bus.ldst_req_wdata),
    .i_rword  (io_bus.dbus_rsp_rdata),
    .o_err    (w_err),
    .o_wstrb  (w_wstrb),
    .o_wdata  (w_wdata),
    .o_rdata  (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_err ? ST_RSP : ST_BREQ;
      ST_BREQ: if (io_bus.dbus_req_rdy) w_state_nxt = ST_BRSP;
      ST_BRSP: if (io_bus.dbus_rsp_vld) w_state_nxt = ST_RSP;
      ST_RSP:  if (io_bus.ldst_rsp_rdy) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Bus payload is fully decoded at accept time so dbus outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st     <= 1'b0;
      r_funct3 <= 3'd0;
      r_off    <= 2'd0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wstrb  <= 4'b0000;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_st     <= io_bus.ldst_req_st;
        r_funct3 <= io_bus.ldst_req_funct3;
        r_off    <= io_bus.ldst_req_addr[1:0];
        r_addr   <= {io_bus.ldst_req_addr[XLEN-1:2], 2'b00};
        r_we     <= io_bus.ldst_req_st & ~w_err;
        r_wstrb  <= w_err ? 4'b0000 : w_wstrb;
        r_wdata  <= w_wdata;
        r_err    <= w_err;
        r_rdata  <= '0;
      end
      if (w_bus_done) r_rdata <= w_rdata;
    end
  end

  assign io_bus.ldst_req_rdy   = (r_state == ST_IDLE);
  assign io_bus.dbus_req_vld   = (r_state == ST_BREQ);
  assign io_bus.dbus_rsp_rdy   = (r_state == ST_BRSP);
  assign io_bus.ldst_rsp_vld   = (r_state == ST_RSP);
  assign io_bus.dbus_req_we    = r_we;
  assign io_bus.dbus_req_addr  = r_addr;
  assign io_bus.dbus_req_wdata = r_wdata;
  assign io_bus.dbus_req_wstrb = r_wstrb;
  assign io_bus.ldst_rsp_rdata = r_rdata;
  assign io_bus.ldst_rsp_err   = r_err;

endmodule

// File: tb/tb_ldst_unit.sv
module tb_ldst_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ldst_unit_if #(.XLEN(32)) bus ();
  ldst_unit #(.XLEN(32)) dut (.clk(clk), .rst(rst), .io_bus(bus));

  int checks = 0;
  int errors = 0;
  int n_rsp  = 0;
  int n_bhs  = 0;

  // Handshake counters seen at the clock edge
  always @(posedge clk) begin
    if (bus.ldst_rsp_vld && bus.ldst_rsp_rdy) n_rsp++;
    if (bus.dbus_req_vld && bus.dbus_req_rdy) n_bhs++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (byte-oriented) ----------------
  function automatic int m_nbytes(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic m_err(input logic st, input logic [2:0] f3, input logic [31:0] addr);
    int idx;
    idx = int'(addr[1:0]);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if (st && f3 > 3'd2) return 1'b1;
    return (idx % m_nbytes(f3)) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] word);
    logic [31:0] v;
    int n, idx;
    n = m_nbytes(f3);
    idx = int'(addr[1:0]);
    v = '0;
    for (int b = 0; b < n; b++) v[8*b +: 8] = word[8*(idx+b) +: 8];
    if (f3 < 3'd4 && n < 4 && v[8*n-1])
      for (int b = n; b < 4; b++) v[8*b +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [3:0] m_strb(input logic st, input logic [2:0] f3, input logic [31:0] addr);
    logic [3:0] s;
    int n, idx;
    n = m_nbytes(f3);
    idx = int'(addr[1:0]);
    for (int b = 0; b < 4; b++) s[b] = st && (b >= idx) && (b < idx + n);
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] w;
    int n;
    n = m_nbytes(f3);
    for (int b = 0; b < 4; b++) w[8*b +: 8] = wd[8*(b % n) +: 8];
    return w;
  endfunction

  // ---------------- one complete transaction ----------------
  task automatic do_txn(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rword,
                        input int breq_stall, input int brsp_delay, input int rsp_stall,
                        output logic [31:0] o_rdata, output logic o_err,
                        output logic [3:0] o_wstrb, output logic [31:0] o_wdata);
    logic        e;
    logic [31:0] exp_rd, exp_wd;
    logic [3:0]  exp_strb;
    int          nrsp0, nbhs0, k;
    bit          done;
    e        = m_err(st, f3, addr);
    exp_rd   = (e || st) ? 32'h0 : m_load(f3, addr, rword);
    exp_strb = e ? 4'b0000 : m_strb(st, f3, addr);
    exp_wd   = m_wdata(f3, wdata);
    o_rdata = '0; o_err = 1'b0; o_wstrb = '0; o_wdata = '0;

    @(negedge clk);
    chk("req_rdy_idle", 32'(bus.ldst_req_rdy), 32'd1);
    bus.ldst_req_vld    = 1'b1;
    bus.ldst_req_st     = st;
    bus.ldst_req_funct3 = f3;
    bus.ldst_req_addr   = addr;
    bus.ldst_req_wdata  = wdata;
    bus.dbus_req_rdy    = 1'b0;
    bus.ldst_rsp_rdy    = 1'b0;
    nrsp0 = n_rsp;
    nbhs0 = n_bhs;
    @(posedge clk);
    @(negedge clk);
    bus.ldst_req_vld   = 1'b0;
    bus.ldst_req_wdata = $urandom;

    if (e) begin
      chk("err_no_dbus_vld", 32'(bus.dbus_req_vld), 32'd0);
    end else begin
      k = 0; done = 0;
      o_wstrb = bus.dbus_req_wstrb;
      o_wdata = bus.dbus_req_wdata;
      while (!done) begin
        chk("dbus_req_vld", 32'(bus.dbus_req_vld), 32'd1);
        chk("req_rdy_busy", 32'(bus.ldst_req_rdy), 32'd0);
        chk("rsp_vld_early", 32'(bus.ldst_rsp_vld), 32'd0);
        chk("dbus_addr", bus.dbus_req_addr, {addr[31:2], 2'b00});
        chk("dbus_we", 32'(bus.dbus_req_we), 32'(st));
        chk("dbus_wstrb", 32'(bus.dbus_req_wstrb), 32'(exp_strb));
        if (st) chk("dbus_wdata", bus.dbus_req_wdata, exp_wd);
        bus.dbus_req_rdy = (k >= breq_stall);
        done = bus.dbus_req_rdy;
        @(posedge clk);
        @(negedge clk);
        k++;
      end
      bus.dbus_req_rdy = 1'b0;
      k = 0; done = 0;
      while (!done) begin
        chk("dbus_rsp_rdy", 32'(bus.dbus_rsp_rdy), 32'd1);
        chk("dbus_req_vld_brsp", 32'(bus.dbus_req_vld), 32'd0);
        chk("rsp_vld_brsp", 32'(bus.ldst_rsp_vld), 32'd0);
        bus.dbus_rsp_vld   = (k >= brsp_delay);
        bus.dbus_rsp_rdata = bus.dbus_rsp_vld ? rword : $urandom;
        done = bus.dbus_rsp_vld;
        @(posedge clk);
        @(negedge clk);
        k++;
      end
      // Keep a valid-but-ignored bus response around with junk data.
      bus.dbus_rsp_vld   = 1'b1;
      bus.dbus_rsp_rdata = $urandom;
    end

    k = 0; done = 0;
    while (!done) begin
      chk("rsp_vld", 32'(bus.ldst_rsp_vld), 32'd1);
      chk("rsp_err", 32'(bus.ldst_rsp_err), 32'(e));
      chk("rsp_rdata", bus.ldst_rsp_rdata, exp_rd);
      chk("req_rdy_rsp", 32'(bus.ldst_req_rdy), 32'd0);
      chk("dbus_rsp_rdy_rsp", 32'(bus.dbus_rsp_rdy), 32'd0);
      o_rdata = bus.ldst_rsp_rdata;
      o_err   = bus.ldst_rsp_err;
      bus.ldst_rsp_rdy = (k >= rsp_stall);
      done = bus.ldst_rsp_rdy;
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    bus.ldst_rsp_rdy = 1'b0;
    chk("rsp_vld_drop", 32'(bus.ldst_rsp_vld), 32'd0);
    chk("req_rdy_back", 32'(bus.ldst_req_rdy), 32'd1);
    chk("rsp_count", 32'(n_rsp - nrsp0), 32'd1);
    chk("dbus_hs_count", 32'(n_bhs - nbhs0), e ? 32'd0 : 32'd1);
  endtask

  logic [31:0] rd, wd, a, w, rw;
  logic [3:0]  ws;
  logic        er, st;
  logic [2:0]  f3;
  int          s0, s1, s2;

  initial begin
    rst = 1'b1;
    bus.ldst_req_vld    = 1'b0;
    bus.ldst_req_st     = 1'b0;
    bus.ldst_req_funct3 = 3'd0;
    bus.ldst_req_addr   = '0;
    bus.ldst_req_wdata  = '0;
    bus.ldst_rsp_rdy    = 1'b0;
    bus.dbus_req_rdy    = 1'b0;
    bus.dbus_rsp_vld    = 1'b1;
    bus.dbus_rsp_rdata  = 32'h5A5A_A5A5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_req_rdy", 32'(bus.ldst_req_rdy), 32'd1);
    chk("rst_rsp_vld", 32'(bus.ldst_rsp_vld), 32'd0);
    chk("rst_dbus_vld", 32'(bus.dbus_req_vld), 32'd0);
    chk("rst_dbus_rsp_rdy", 32'(bus.dbus_rsp_rdy), 32'd0);
    chk("rst_err", 32'(bus.ldst_rsp_err), 32'd0);
    chk("rst_rdata", bus.ldst_rsp_rdata, 32'd0);
    chk("rst_wstrb", 32'(bus.dbus_req_wstrb), 32'd0);
    chk("rst_addr", bus.dbus_req_addr, 32'd0);

    // Directed cases
    do_txn(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0, rd, er, ws, wd);
    chk("tp_lw_rdata", rd, 32'hDEADBEEF);
    chk("tp_lw_err", 32'(er), 32'd0);
    do_txn(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_0000, 0, 0, 0, rd, er, ws, wd);
    chk("tp_lb_rdata", rd, 32'hFFFF_FF80);
    do_txn(1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF_0000, 0, 0, 0, rd, er, ws, wd);
    chk("tp_lbu_rdata", rd, 32'h0000_0080);
    do_txn(1'b0, 3'd1, 32'h102, 32'h0, 32'h80FF_0000, 0, 0, 0, rd, er, ws, wd);
    chk("tp_lh_rdata", rd, 32'hFFFF_80FF);
    do_txn(1'b1, 3'd0, 32'h201, 32'h1234_5678, 32'hCAFE_F00D, 0, 0, 0, rd, er, ws, wd);
    chk("tp_sb_wstrb", 32'(ws), 32'h2);
    chk("tp_sb_wdata", wd, 32'h7878_7878);
    chk("tp_sb_rdata", rd, 32'h0);
    chk("tp_sb_err", 32'(er), 32'd0);
    do_txn(1'b0, 3'd2, 32'h102, 32'h0, 32'h1111_1111, 0, 0, 0, rd, er, ws, wd);
    chk("tp_lw_mis_err", 32'(er), 32'd1);
    chk("tp_lw_mis_rdata", rd, 32'h0);
    do_txn(1'b1, 3'd1, 32'h1, 32'hABCD, 32'h0, 0, 0, 0, rd, er, ws, wd);
    chk("tp_sh_mis_err", 32'(er), 32'd1);
    do_txn(1'b0, 3'd2, 32'h104, 32'h0, 32'h0BAD_CAFE, 3, 1, 2, rd, er, ws, wd);
    chk("tp_bp_rdata", rd, 32'h0BAD_CAFE);

    // Reset while waiting for the bus response
    @(negedge clk);
    bus.ldst_req_vld = 1'b1; bus.ldst_req_st = 1'b0;
    bus.ldst_req_funct3 = 3'd2; bus.ldst_req_addr = 32'h300;
    bus.dbus_req_rdy = 1'b1; bus.dbus_rsp_vld = 1'b0;
    @(posedge clk); @(negedge clk);
    bus.ldst_req_vld = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("mid_in_brsp", 32'(bus.dbus_rsp_rdy), 32'd1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    bus.dbus_req_rdy = 1'b0; bus.dbus_rsp_vld = 1'b1;
    chk("mid_req_rdy", 32'(bus.ldst_req_rdy), 32'd1);
    chk("mid_rsp_vld", 32'(bus.ldst_rsp_vld), 32'd0);
    chk("mid_dbus_vld", 32'(bus.dbus_req_vld), 32'd0);
    chk("mid_dbus_rsp_rdy", 32'(bus.dbus_rsp_rdy), 32'd0);
    do_txn(1'b0, 3'd2, 32'h308, 32'h0, 32'h1357_9BDF, 0, 0, 0, rd, er, ws, wd);
    chk("mid_after_rdata", rd, 32'h1357_9BDF);

    // Randomized traffic checked against the byte-level model inside do_txn
    for (int i = 0; i < 200; i++) begin
      st = 1'($urandom_range(1, 0));
      f3 = 3'($urandom_range(7, 0));
      a  = $urandom;
      if ($urandom_range(1, 0) == 1) a[1:0] = 2'b00;
      w  = $urandom;
      rw = $urandom;
      s0 = ($urandom_range(3, 0) == 0) ? int'($urandom_range(3, 1)) : 0;
      s1 = ($urandom_range(3, 0) == 0) ? int'($urandom_range(3, 1)) : 0;
      s2 = ($urandom_range(3, 0) == 0) ? int'($urandom_range(3, 1)) : 0;
      do_txn(st, f3, a, w, rw, s0, s1, s2, rd, er, ws, wd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
